// File: rtl/fwd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fwd_pkg
// Purpose  : Shared constants and width helpers for the forwarding / hazard
//            scoreboard slice.
// Contents : FWD_SEL_RF        - fwd_sel value that selects the register file
//            sel_width()       - width of one per-operand forward select
//            cnt_width()       - width of one latency counter
//            slice_lo()        - LSB of element idx in a packed vector
// Revision : 1.0 - initial release
// ============================================================================
package fwd_pkg;

  localparam int FWD_SEL_RF = 0;

  // One code per bypass stage plus the register-file code.
  function automatic int sel_width(input int fwd_stages);
    return (fwd_stages < 1) ? 1 : $clog2(fwd_stages + 1);
  endfunction

  // Counter must hold 0..max_lat inclusive.
  function automatic int cnt_width(input int max_lat);
    return (max_lat < 1) ? 1 : $clog2(max_lat + 1);
  endfunction

  // Operand/stage i of a packed bus lives at [slice_lo(i, w) +: w].
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_scoreboard_if
// Purpose  : Issue / bypass-stage bundle between decode-issue and the
//            forwarding-hazard unit.
// Modports : master - issue side, drives issue and stage info, reads results
//            slave  - the hazard unit itself
// Signals  : flush, issue_valid/we/rd/lat, src_addr, stage_we/rd  (to unit)
//            fwd_sel, stall, stall_cycles                          (from unit)
// Revision : 1.0 - initial release
// ============================================================================
interface fwd_hazard_scoreboard_if
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 2,
  parameter int MAX_LAT    = 4,
  parameter int STAT_W     = 16
) ();

  localparam int SEL_W = sel_width(FWD_STAGES);
  localparam int LAT_W = cnt_width(MAX_LAT);

  logic                             flush;
  logic                             issue_valid;
  logic                             issue_we;
  logic [REG_ADDR_W-1:0]            issue_rd;
  logic [LAT_W-1:0]                 issue_lat;
  logic [NUM_SRC*REG_ADDR_W-1:0]    src_addr;
  logic [FWD_STAGES-1:0]            stage_we;
  logic [FWD_STAGES*REG_ADDR_W-1:0] stage_rd;
  logic [NUM_SRC*SEL_W-1:0]         fwd_sel;
  logic                             stall;
  logic [STAT_W-1:0]                stall_cycles;

  modport master (
    output flush, issue_valid, issue_we, issue_rd, issue_lat, src_addr,
           stage_we, stage_rd,
    input  fwd_sel, stall, stall_cycles
  );

  modport slave (
    input  flush, issue_valid, issue_we, issue_rd, issue_lat, src_addr,
           stage_we, stage_rd,
    output fwd_sel, stall, stall_cycles
  );

endinterface
`default_nettype wire

// File: rtl/fwd_hazard_scoreboard_sb_entry.sv
`default_nettype none
// ============================================================================
// Module   : sb_entry
// Purpose  : One scoreboard slot: latency down-counter for a single register.
// Ports    : clk, pc_rst (async, active-high)
//            clr       - synchronous clear, beats load
//            load      - load load_val (clamped to MAX_LAT), beats decrement
//            load_val  - producer latency
//            busy      - counter nonzero
// Revision : 1.0 - initial release
// ============================================================================
module sb_entry #(
  parameter int CNT_W   = 3,
  parameter int MAX_LAT = 4
) (
  input  wire logic             clk,
  input  wire logic             pc_rst,
  input  wire logic             clr,
  input  wire logic             load,
  input  wire logic [CNT_W-1:0] load_val,
  output logic                  busy
);

  localparam logic [CNT_W-1:0] c_max_lat = CNT_W'(MAX_LAT);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_load_clamped;

  assign w_load_clamped = (load_val > c_max_lat) ? c_max_lat : load_val;

  always_ff @(posedge clk or posedge pc_rst) begin
    if (pc_rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= w_load_clamped;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign busy = (r_cnt != '0);

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_scoreboard
// Purpose  : Operand forwarding select for NUM_SRC sources over FWD_STAGES
//            bypass stages, plus a per-register latency scoreboard that
//            stalls issue until variable-latency results are forwardable.
// Ports    : clk     - rising-edge clock
//            pc_rst  - asynchronous active-high reset
//            bus     - fwd_hazard_scoreboard_if.slave (issue, stage, results)
// Revision : 1.0 - initial release
// ============================================================================
module fwd_hazard_scoreboard
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 2,
  parameter int MAX_LAT    = 4,
  parameter int STAT_W     = 16
) (
  input wire logic                  clk,
  input wire logic                  pc_rst,
  fwd_hazard_scoreboard_if.slave    bus
);

  localparam int SEL_W = sel_width(FWD_STAGES);
  localparam int CNT_W = cnt_width(MAX_LAT);
  localparam int NREG  = 1 << REG_ADDR_W;
  localparam logic [STAT_W-1:0] c_stat_max = '1;

  logic [NREG-1:0]          w_busy;
  logic [REG_ADDR_W-1:0]    w_src [NUM_SRC];
  logic                     w_stall;
  logic                     w_accept;
  logic [NUM_SRC*SEL_W-1:0] w_fwd_sel;
  logic [STAT_W-1:0]        r_stall_cycles;

  assign w_accept = bus.issue_valid && !w_stall;

  // Register 0 is hardwired zero: never tracked, never busy.
  assign w_busy[0] = 1'b0;

  generate
    for (genvar r = 1; r < NREG; r++) begin : g_sb
      sb_entry #(
        .CNT_W   (CNT_W),
        .MAX_LAT (MAX_LAT)
      ) u_sb_entry (
        .clk      (clk),
        .pc_rst   (pc_rst),
        .clr      (bus.flush),
        .load     (w_accept && bus.issue_we &&
                   (bus.issue_rd == REG_ADDR_W'(r))),
        .load_val (bus.issue_lat),
        .busy     (w_busy[r])
      );
    end
  endgenerate

  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      assign w_src[i] = bus.src_addr[slice_lo(i, REG_ADDR_W) +: REG_ADDR_W];
    end
  endgenerate

  always_comb begin
    w_stall = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if ((w_src[i] != '0) && w_busy[w_src[i]]) begin
        w_stall = 1'b1;
      end
    end
    w_stall = w_stall && bus.issue_valid;
  end

  // Scan oldest to youngest so the youngest matching stage overwrites.
  always_comb begin
    w_fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_fwd_sel[slice_lo(i, SEL_W) +: SEL_W] = SEL_W'(FWD_SEL_RF);
      for (int k = FWD_STAGES - 1; k >= 0; k--) begin
        if (bus.stage_we[k] && (w_src[i] != '0) &&
            (bus.stage_rd[slice_lo(k, REG_ADDR_W) +: REG_ADDR_W] == w_src[i])) begin
          w_fwd_sel[slice_lo(i, SEL_W) +: SEL_W] = SEL_W'(k + 1);
        end
      end
    end
  end

  // Statistics survive flush; only reset clears them.
  always_ff @(posedge clk or posedge pc_rst) begin
    if (pc_rst) begin
      r_stall_cycles <= '0;
    end else if (w_stall && (r_stall_cycles != c_stat_max)) begin
      r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign bus.stall        = w_stall;
  assign bus.fwd_sel      = w_fwd_sel;
  assign bus.stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire
